// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
// Owns the PC, drives a single-outstanding icache read handshake, buffers
// fetched words in a DEPTH-entry FIFO and slices decode fields off the head.
// Optional macro FETCH_PERF_EN adds stall/flush/discard performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic        icache_resp,
    input  logic [31:0] icache_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        decode_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_discard_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    logic [0:0]       state_q;
    logic [31:0]      pc_q;
    logic [31:0]      discard_addr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [31:0]      fifo_inst_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];

    logic has_space;
    logic push;
    logic pop;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Request and FIFO handshake decode; outputs depend only on registered state
    // (plus rst so nothing is requested in a reset cycle).
    always_comb begin
        has_space      = count_q < DEPTH_C;
        icache_read    = !rst && ((state_q == ST_DISCARD) || has_space);
        icache_address = (state_q == ST_DISCARD) ? discard_addr_q : pc_q;
        inst_valid     = count_q != '0;
        push           = (state_q == ST_FETCH) && icache_read && icache_resp && !redirect;
        pop            = inst_valid && decode_ready && !redirect;
        inst           = inst_valid ? fifo_inst_q[rd_ptr_q] : NOP;
        inst_pc        = fifo_pc_q[rd_ptr_q];
        opcode         = inst[6:0];
        funct3         = inst[14:12];
        funct7         = inst[31:25];
    end

    // PC, state and FIFO bookkeeping; redirect flushes and takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            discard_addr_q <= RESET_PC;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
        end else if (redirect) begin
            pc_q     <= {redirect_pc[31:2], 2'b00};
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            if (state_q == ST_FETCH) begin
                // Wrong-path request still in flight: hold its address until resp.
                if (icache_read && !icache_resp) begin
                    state_q        <= ST_DISCARD;
                    discard_addr_q <= pc_q;
                end
            end else if (icache_resp) begin
                state_q <= ST_FETCH;
            end
        end else begin
            if ((state_q == ST_DISCARD) && icache_resp) begin
                state_q <= ST_FETCH;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                pc_q     <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= icache_rdata;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic drop;
    assign drop = icache_resp && ((state_q == ST_DISCARD) || (icache_read && redirect));

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles  <= '0;
            perf_flush_count   <= '0;
            perf_discard_count <= '0;
        end else begin
            if (!inst_valid && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect && (perf_flush_count != '1)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
            if (drop && (perf_discard_count != '1)) begin
                perf_discard_count <= perf_discard_count + 32'd1;
            end
        end
    end
`endif

endmodule
